// File: rtl/rf_op_seq_pkg.sv
// Shared opcodes and FSM state encoding for the rf_op_seq register-file sequencer.
package rf_op_seq_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  // Only the two-operand arithmetic/logic ops touch the carry and zero flags.
  function automatic logic op_sets_flags(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/rf_op_alu.sv
// Combinational ALU for rf_op_seq: (op, a, b) -> (result, carry).
module rf_op_alu
  import rf_op_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] ext;

  // Work one bit wider so the top bit carries the ADD carry-out or SUB borrow.
  always_comb begin
    ext = '0;
    case (op)
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_AND:  ext = {1'b0, a & b};
      OP_OR:   ext = {1'b0, a | b};
      OP_XOR:  ext = {1'b0, a ^ b};
      OP_MOV:  ext = {1'b0, a};
      default: ext = '0;
    endcase
  end

  assign result = ext[DATA_W-1:0];
  assign carry  = ext[DATA_W];

endmodule

// File: rtl/rf_op_seq.sv
// rf_op_seq: instruction sequencer driving both ports of a small register file.
// Optional flag registers are built when RF_OP_SEQ_FLAGS_EN is defined; otherwise
// flag_c/flag_z are tied to 0.
module rf_op_seq
  import rf_op_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_dst,
  input  logic [ADDR_W-1:0] instr_src_a,
  input  logic [ADDR_W-1:0] instr_src_b,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_e,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              done,
  output logic              flag_c,
  output logic              flag_z
);

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   dst_q, src_a_q, src_b_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q, result_q;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;

  rf_op_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (op_a_q),
    .b      (op_b_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // State register plus instruction capture, operand fetch and result latch.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q     <= instr_op;
            dst_q    <= instr_dst;
            src_a_q  <= instr_src_a;
            src_b_q  <= instr_src_b;
            result_q <= (instr_op == OP_LDI) ? instr_imm : '0;
          end
        end
        ST_RD_A: op_a_q   <= rf_rd_data;
        ST_RD_B: op_b_q   <= rf_rd_data;
        ST_EXEC: result_q <= alu_result;
        default: ;
      endcase
    end
  end

  // Next-state and port drive; write/done are held off while reset is asserted.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_rd_addr  = '0;
    rf_wr_e     = 1'b0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (instr_op == OP_NOP || instr_op == OP_LDI) state_d = ST_WB;
          else                                          state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        rf_rd_addr = src_a_q;
        state_d    = (op_q == OP_MOV) ? ST_EXEC : ST_RD_B;
      end
      ST_RD_B: begin
        rf_rd_addr = src_b_q;
        state_d    = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        done = rst_b;
        if (op_q != OP_NOP) begin
          rf_wr_e    = rst_b;
          rf_wr_addr = dst_q;
          rf_wr_data = result_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RF_OP_SEQ_FLAGS_EN
  logic carry_q, flag_c_q, flag_z_q;

  // Carry is captured with the result; flags commit at writeback of ALU ops only.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      carry_q  <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      if (state_q == ST_EXEC) carry_q <= alu_carry;
      if (state_q == ST_WB && op_sets_flags(op_q)) begin
        flag_c_q <= carry_q;
        flag_z_q <= (result_q == '0);
      end
    end
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
`else
  logic carry_unused;
  assign carry_unused = alu_carry;
  assign flag_c       = 1'b0;
  assign flag_z       = 1'b0;
`endif

endmodule
